afifo_warb: RTL and testbench
=============================

AFIFO_WARB -- requirements
Module: afifo_warb

Interface
REQ-001 Parameter NREQ, default 4, is the number of write requesters; the supported range is 2 to 4.
REQ-002 Parameter DW, default 8, is the data width, equal to the FIFO wdata width.
REQ-003 Parameter MAX_BURST, default 4, is the maximum number of words written per grant; the supported range is 1 to 15.
REQ-004 The block SHALL have one clock and one reset: wclk  in  1  write-domain clock, all logic on its rising edge.
REQ-005 wrst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  NREQ  per-requester valid; a word is offered while high.
REQ-007 req_data  in  NREQ*DW  per-requester data; slice i is bits [i*DW +: DW].
REQ-008 req_ready  out  NREQ  per-requester accept; a word transfers when valid and ready are both high at a wclk edge.
REQ-009 wfull  in  1  FIFO full flag, already in the wclk domain.
REQ-010 winc  out  1  FIFO write enable.
REQ-011 wdata  out  DW  FIFO write data.
REQ-012 gnt  out  NREQ  one-hot grant, registered.
REQ-013 gnt_id  out  2  index of the granted requester, registered.
REQ-014 xfer_cnt  out  16  total words written to the FIFO, wrapping.

Function
REQ-015 The FSM SHALL have 2 states: IDLE (no grant, gnt=0) and GRANT (exactly one gnt bit set).
REQ-016 In IDLE, if any req_valid bit is high, the block SHALL pick the first valid requester scanning upward from rr_ptr, modulo NREQ, and enter GRANT at the next edge, loading gnt, gnt_id and burst_cnt=0.
REQ-017 In IDLE with no req_valid bit high, the block SHALL stay in IDLE.
REQ-018 Combinational outputs: req_ready[g] = GRANT & ~wfull; every other req_ready bit SHALL be 0.
REQ-019 Combinational outputs: winc = GRANT & req_valid[g] & ~wfull.
REQ-020 Combinational outputs: wdata = req_data slice g while in GRANT; wdata = 0 otherwise.
REQ-021 There SHALL be no write into a full FIFO: winc is never high in a cycle where wfull is high.
REQ-022 Each transfer SHALL increment burst_cnt and xfer_cnt by 1; xfer_cnt wraps from 0xFFFF to 0x0000.
REQ-023 GRANT SHALL be released at the edge ending the transfer for which burst_cnt == MAX_BURST-1.
REQ-024 GRANT SHALL also be released at any edge where req_valid[g] is low; a requester may withdraw with no penalty.
REQ-025 While in GRANT with wfull high, the grant SHALL be held, with no count change and no timeout.
REQ-026 On release, rr_ptr SHALL become (g+1) mod NREQ and the state SHALL return to IDLE for exactly one cycle, the arbitration bubble.
REQ-027 Latency: req_valid rising at edge N gives gnt at N+1; the first winc can occur in the cycle after edge N+1.
REQ-028 Throughput: a burst of MAX_BURST words with wfull low SHALL complete in MAX_BURST consecutive cycles.
REQ-029 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,2,3,0,... each receiving MAX_BURST words.
REQ-030 If wfull and req_valid[g] change in the same cycle, REQ-019 and REQ-024 SHALL both apply independently.

Reset
REQ-031 While wrst_n is low, the block SHALL hold: state=IDLE, gnt=0, gnt_id=0, rr_ptr=0, burst_cnt=0, xfer_cnt=0.
REQ-032 While wrst_n is low, winc=0, wdata=0 and req_ready=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst immediately and combinationally force winc=0; no partial write occurs after assertion.
REQ-034 After wrst_n deasserts, the first grant SHALL occur no earlier than the second wclk edge.

Verification
REQ-035 Single requester: req_valid=0001, data 1..8, wfull=0, MAX_BURST=4 -> words 1-4 written, 1 bubble, 5-8 written; xfer_cnt=8; gnt pattern 0001,0000,0001.
REQ-036 Round robin: all 4 requesters valid continuously -> gnt_id sequence 0,1,2,3,0; each burst is 4 winc pulses; 1 idle cycle between bursts.
REQ-037 Full stall: wfull forced high after 2 words of a burst for 5 cycles -> winc=0 and req_ready=0 for those 5 cycles, grant held; the remaining 2 words are written after wfull falls.
REQ-038 Withdraw: requester 2 drops valid after 1 word while requester 3 is waiting -> grant released, bubble, then gnt_id=3.
REQ-039 Reset mid-burst: wrst_n low during the 3rd word -> gnt=0, winc=0 and xfer_cnt=0 at once; after release requester 0 is granted first (rr_ptr=0).
REQ-040 Wrap: preload traffic to 65535 words, then write 2 more -> xfer_cnt reads 0x0001.

Source files
------------

// File: rtl/afifo_warb.sv
// Round-robin burst arbiter feeding an async FIFO write port; grant registered one edge after valid.
// Backpressure: wfull holds the grant and gates winc/req_ready combinationally; withdrawal releases it.
module afifo_warb #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                wfull,
  output logic                winc,
  output logic [DW-1:0]       wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [1:0]          gnt_id,
  output logic [15:0]         xfer_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] rr_ptr;
  logic [3:0] burst_cnt;
  logic       armed;
  logic       granted;
  logic       xfer;
  logic       release_g;
  logic       pick_vld;
  logic [1:0] pick_id;
  logic [1:0] next_ptr;
  int         idx;

  // Gating with wrst_n makes a reset mid-burst kill the write in the same cycle.
  assign granted   = (state == GRANT) & wrst_n;
  assign xfer      = granted & req_valid[gnt_id] & ~wfull;
  assign winc      = xfer;
  assign wdata     = granted ? req_data[gnt_id*DW +: DW] : '0;
  assign release_g = ~req_valid[gnt_id] |
                     (xfer & (burst_cnt == 4'(MAX_BURST - 1)));
  assign next_ptr  = (gnt_id == 2'(NREQ - 1)) ? 2'd0 : gnt_id + 2'd1;

  always_comb begin
    req_ready = '0;
    if (granted & ~wfull)
      req_ready[gnt_id] = 1'b1;
  end

  // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    idx      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = 2'(idx);
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= 2'd0;
      rr_ptr    <= 2'd0;
      burst_cnt <= 4'd0;
      xfer_cnt  <= 16'd0;
      armed     <= 1'b0;
    end else begin
      // First edge after reset only arms the arbiter; grants start on the second.
      armed <= 1'b1;
      if (state == IDLE) begin
        if (armed && pick_vld) begin
          state     <= GRANT;
          gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
          gnt_id    <= pick_id;
          burst_cnt <= 4'd0;
        end
      end else begin
        if (xfer) begin
          burst_cnt <= burst_cnt + 4'd1;
          xfer_cnt  <= xfer_cnt + 16'd1;
        end
        if (release_g) begin
          state  <= IDLE;
          gnt    <= '0;
          rr_ptr <= next_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_afifo_warb.sv
// Scoreboard bench: a transaction-level arbiter model predicts every cycle's outputs;
// a second instance with long bursts walks xfer_cnt through its 16-bit wrap.
module tb_afifo_warb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic              wclk;
  logic              wrst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wfull;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        gnt_id;
  logic [15:0]       xfer_cnt;

  logic              w_rst_n;
  logic [1:0]        w_valid;
  logic [15:0]       w_data;
  logic [1:0]        w_ready;
  logic              w_winc;
  logic [7:0]        w_wdata;
  logic [1:0]        w_gnt;
  logic [1:0]        w_gnt_id;
  logic [15:0]       w_cnt;
  logic              w_full;
  logic              wrap_done;

  afifo_warb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) u_dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .gnt(gnt), .gnt_id(gnt_id), .xfer_cnt(xfer_cnt));

  afifo_warb #(.NREQ(2), .DW(8), .MAX_BURST(15)) u_wrap (
    .wclk(wclk), .wrst_n(w_rst_n), .req_valid(w_valid), .req_data(w_data),
    .req_ready(w_ready), .wfull(w_full), .winc(w_winc), .wdata(w_wdata),
    .gnt(w_gnt), .gnt_id(w_gnt_id), .xfer_cnt(w_cnt));

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct packed {
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [NREQ-1:0] ready;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gid;
    logic            gid_chk;
    logic [15:0]     cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: current owner (-1 when idle), words left in its burst, next start point.
  int          m_owner;
  int          m_last;
  int          m_left;
  int          m_ptr;
  int          m_armed;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_left  = 0;
    m_ptr   = 0;
    m_armed = 0;
    m_cnt   = 16'd0;
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic f, input logic r);
    exp_t            e;
    logic [DW-1:0]   d [NREQ];
    logic            wr;
    int              was_armed;
    @(posedge wclk);
    #1;
    req_valid = v;
    wfull     = f;
    wrst_n    = r;
    for (int i = 0; i < NREQ; i++) begin
      d[i] = DW'($urandom);
      req_data[i*DW +: DW] = d[i];
    end
    if (!r) model_reset();
    wr        = (m_owner >= 0) && v[m_owner] && !f;
    e.winc    = wr;
    e.wdata   = (m_owner >= 0) ? d[m_owner] : '0;
    e.ready   = (m_owner >= 0 && !f) ? NREQ'(1 << m_owner) : '0;
    e.gnt     = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    e.gid     = 2'(m_last);
    e.gid_chk = (m_owner >= 0) || !r;
    e.cnt     = m_cnt;
    sb.push_back(e);
    if (r) begin
      was_armed = m_armed;
      m_armed   = 1;
      if (m_owner < 0) begin
        if (was_armed != 0) begin
          for (int k = NREQ - 1; k >= 0; k--)
            if (v[(m_ptr + k) % NREQ]) m_last = (m_ptr + k) % NREQ;
          if (v != '0) begin
            m_owner = m_last;
            m_left  = MB;
          end
        end
      end else begin
        if (wr) begin
          m_cnt  = m_cnt + 16'd1;
          m_left = m_left - 1;
        end
        if (!v[m_owner] || m_left == 0) begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
    end
  endtask

  always @(negedge wclk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("winc", 32'(winc), 32'(e.winc));
      chk("wdata", 32'(wdata), 32'(e.wdata));
      chk("req_ready", 32'(req_ready), 32'(e.ready));
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(e.cnt));
      if (e.gid_chk) chk("gnt_id", 32'(gnt_id), 32'(e.gid));
      if (winc && wfull) chk("write_into_full", 32'(winc & wfull), 32'd0);
    end
  end

  // Wrap instance: 2 requesters always valid, bursts of 15 then one bubble edge,
  // so word 15p+r lands on edge 3+16p+(r-1) after reset release.
  initial begin
    wrap_done = 1'b0;
    w_rst_n   = 1'b0;
    w_valid   = 2'b11;
    w_data    = 16'h5aa5;
    w_full    = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    chk("wrap_reset_cnt", 32'(w_cnt), 32'd0);
    w_rst_n = 1'b1;
    for (int e = 1; e <= 69908; e++) begin
      @(posedge wclk);
      #1;
      if (e == 2)     chk("wrap_first_gnt", 32'(w_gnt), 32'b01);
      if (e == 17)    chk("wrap_cnt_15", 32'(w_cnt), 32'd15);
      if (e == 18)    chk("wrap_rotate", 32'(w_gnt_id), 32'd1);
      if (e == 69907) chk("wrap_cnt_0", 32'(w_cnt), 32'd0);
      if (e == 69908) chk("wrap_cnt_1", 32'(w_cnt), 32'd1);
    end
    wrap_done = 1'b1;
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    model_reset();

    repeat (3) step(4'b0000, 1'b0, 1'b0);
    // Valid already high as reset releases: grant must wait for the second edge.
    repeat (12) step(4'b0001, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);
    repeat (26) step(4'b1111, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) step(4'b0001, (c >= 3 && c <= 7), 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);
    repeat (2) step(4'b1100, 1'b0, 1'b1);
    repeat (6) step(4'b1000, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b0001, 1'b0, 1'b1);
    repeat (2) step(4'b0001, 1'b0, 1'b0);
    repeat (8) step(4'b1111, 1'b0, 1'b1);
    // Wfull and withdrawal toggling together, then free-running random traffic.
    for (int c = 0; c < 40; c++) step(4'($urandom), 1'($urandom), 1'b1);
    for (int c = 0; c < 1500; c++) begin
      logic [NREQ-1:0] v;
      for (int i = 0; i < NREQ; i++) v[i] = ($urandom_range(0, 9) < 7);
      step(v, ($urandom_range(0, 4) == 0), ($urandom_range(0, 299) != 0));
    end
    step(4'b0000, 1'b0, 1'b1);
    @(posedge wclk);

    for (int i = 0; i < 80000 && !wrap_done; i++) @(posedge wclk);
    if (!wrap_done) chk("wrap_timeout", 32'd0, 32'd1);
    @(negedge wclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
